// File: rtl/div_scheduler.sv
// Two-requester front end for one shared divider: round-robin grant,
// zero-divisor shortcut and a bounded wait for the divider's answer.
module div_scheduler #(
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [W-1:0] r0_dividend,
    input  logic [W-1:0] r0_divisor,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [W-1:0] r1_dividend,
    input  logic [W-1:0] r1_divisor,
    output logic         d_valid,
    input  logic         d_ready,
    output logic [W-1:0] d_dividend,
    output logic [W-1:0] d_divisor,
    input  logic         d_rsp_valid,
    input  logic [W-1:0] d_rsp_quotient,
    input  logic [W-1:0] d_rsp_remainder,
    output logic         r0_rsp_valid,
    input  logic         r0_rsp_ready,
    output logic [W-1:0] r0_quotient,
    output logic [W-1:0] r0_remainder,
    output logic         r0_err,
    output logic         r1_rsp_valid,
    input  logic         r1_rsp_ready,
    output logic [W-1:0] r1_quotient,
    output logic [W-1:0] r1_remainder,
    output logic         r1_err,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t        state;
    logic          last_served;
    logic          owner;
    logic          err_q;
    logic [15:0]   cnt;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  res_q;
    logic [W-1:0]  res_r;

    logic          idle;
    logic          deliver;
    logic          g0;
    logic          g1;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          rsp_take;

    // A held-low reset masks every output, whatever state is still registered.
    assign idle    = reset && (state == IDLE);
    assign deliver = reset && (state == DELIVER);

    assign g0 = idle && r0_valid && (!r1_valid || last_served);
    assign g1 = idle && r1_valid && (!r0_valid || !last_served);

    assign r0_ready = g0;
    assign r1_ready = g1;

    assign in_a     = g1 ? r1_dividend : r0_dividend;
    assign in_b     = g1 ? r1_divisor  : r0_divisor;
    assign rsp_take = owner ? r1_rsp_ready : r0_rsp_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
            owner       <= 1'b0;
            err_q       <= 1'b0;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            res_q       <= '0;
            res_r       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (g0 || g1) begin
                        owner <= g1;
                        op_a  <= in_a;
                        op_b  <= in_b;
                        if (in_b == '0) begin
                            res_q <= '1;
                            res_r <= '1;
                            err_q <= 1'b0;
                            state <= DELIVER;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (d_ready) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (d_rsp_valid) begin
                        res_q <= d_rsp_quotient;
                        res_r <= d_rsp_remainder;
                        err_q <= 1'b0;
                        state <= DELIVER;
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        res_q <= '1;
                        res_r <= '1;
                        err_q <= 1'b1;
                        state <= DELIVER;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DELIVER: begin
                    if (rsp_take) begin
                        last_served <= owner;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign d_valid    = reset && (state == ISSUE);
    assign d_dividend = d_valid ? op_a : '0;
    assign d_divisor  = d_valid ? op_b : '0;

    assign r0_rsp_valid = deliver && !owner;
    assign r1_rsp_valid = deliver && owner;

    assign r0_quotient  = r0_rsp_valid ? res_q : '0;
    assign r0_remainder = r0_rsp_valid ? res_r : '0;
    assign r0_err       = r0_rsp_valid && err_q;
    assign r1_quotient  = r1_rsp_valid ? res_q : '0;
    assign r1_remainder = r1_rsp_valid ? res_r : '0;
    assign r1_err       = r1_rsp_valid && err_q;

    assign busy = reset && (state != IDLE);

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural divider and a
// response scoreboard filled at every accepted request.
module tb_div_scheduler;

    localparam int W  = 32;
    localparam int TO = 8;

    typedef struct packed {
        logic         owner;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         r0_valid = 1'b0, r1_valid = 1'b0;
    logic         r0_ready, r1_ready;
    logic [W-1:0] r0_dividend = '0, r0_divisor = '0;
    logic [W-1:0] r1_dividend = '0, r1_divisor = '0;
    logic         d_valid;
    logic         d_ready = 1'b1;
    logic [W-1:0] d_dividend, d_divisor;
    logic         d_rsp_valid;
    logic [W-1:0] d_rsp_quotient = '0, d_rsp_remainder = '0;
    logic         r0_rsp_valid, r1_rsp_valid;
    logic         r0_rsp_ready = 1'b1, r1_rsp_ready = 1'b1;
    logic [W-1:0] r0_quotient, r0_remainder, r1_quotient, r1_remainder;
    logic         r0_err, r1_err, busy;

    logic dv_model = 1'b0;
    logic stray = 1'b0;
    logic div_en = 1'b1;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_issue = 0;
    exp_t sb[$];
    int   acc_log[$];

    assign d_rsp_valid = dv_model | stray;

    div_scheduler #(.W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready),
        .r0_dividend(r0_dividend), .r0_divisor(r0_divisor),
        .r1_valid(r1_valid), .r1_ready(r1_ready),
        .r1_dividend(r1_dividend), .r1_divisor(r1_divisor),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_dividend(d_dividend), .d_divisor(d_divisor),
        .d_rsp_valid(d_rsp_valid),
        .d_rsp_quotient(d_rsp_quotient),
        .d_rsp_remainder(d_rsp_remainder),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r0_quotient(r0_quotient), .r0_remainder(r0_remainder),
        .r0_err(r0_err),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .r1_quotient(r1_quotient), .r1_remainder(r1_remainder),
        .r1_err(r1_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // One-cycle divider: answers the cycle after the issue handshake.
    always @(posedge clk) begin
        dv_model <= d_valid && d_ready && div_en;
        if (d_valid && d_ready && d_divisor != 0) begin
            d_rsp_quotient  <= d_dividend / d_divisor;
            d_rsp_remainder <= d_dividend % d_divisor;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic k, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        e.owner = k;
        if (b == 0) begin
            e.q = '1; e.r = '1; e.err = 1'b0;
        end else if (div_en) begin
            e.q = a / b; e.r = a % b; e.err = 1'b0;
        end else begin
            e.q = '1; e.r = '1; e.err = 1'b1;
        end
        return e;
    endfunction

    task automatic pop_check(input logic k, input logic [W-1:0] q,
                             input logic [W-1:0] r, input logic e);
        exp_t x;
        if (sb.size() == 0) begin
            check("sb_unexpected_rsp", 1, 0);
        end else begin
            x = sb.pop_front();
            check("rsp_owner", k, x.owner);
            check("rsp_quotient", q, x.q);
            check("rsp_remainder", r, x.r);
            check("rsp_err", e, x.err);
        end
    endtask

    always @(negedge clk) begin
        if (r0_valid && r0_ready) begin
            sb.push_back(model(1'b0, r0_dividend, r0_divisor));
            acc_log.push_back(0);
        end
        if (r1_valid && r1_ready) begin
            sb.push_back(model(1'b1, r1_dividend, r1_divisor));
            acc_log.push_back(1);
        end
        if (r0_ready && r1_ready) check("ready_excl", 1, 0);
        if (d_valid && d_ready) n_issue++;
        if (r0_rsp_valid && r0_rsp_ready)
            pop_check(1'b0, r0_quotient, r0_remainder, r0_err);
        if (r1_rsp_valid && r1_rsp_ready)
            pop_check(1'b1, r1_quotient, r1_remainder, r1_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"},
              {r0_ready, r1_ready, d_valid, r0_rsp_valid, r1_rsp_valid,
               busy, r0_err, r1_err}, 8'h00);
        check({tag, "_payload"},
              d_dividend | d_divisor | r0_quotient | r0_remainder
              | r1_quotient | r1_remainder, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        check_quiet("reset_hold");
        tick();
        reset = 1'b1;
        sb.delete();
        acc_log.delete();
    endtask

    task automatic send(input int k, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        if (k == 0) begin
            r0_valid = 1'b1; r0_dividend = a; r0_divisor = b;
        end else begin
            r1_valid = 1'b1; r1_dividend = a; r1_divisor = b;
        end
        #1;
        for (int i = 0; i < 100; i++) begin
            if ((k == 0 && r0_ready) || (k == 1 && r1_ready)) begin
                tick();
                r0_valid = 1'b0;
                r1_valid = 1'b0;
                return;
            end
            tick();
        end
        check("send_timeout", 1, 0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !busy) return;
            tick();
        end
        check("drain_timeout", 1, 0);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 200; i++) begin
            if (acc_log.size() >= n) return;
            tick();
        end
        check("accept_timeout", 1, 0);
    endtask

    int iss0;

    initial begin
        do_reset();
        check_quiet("after_reset");

        // r0 alone, 17/5, best-case latency
        send(0, 17, 5);
        check("lat_dvalid", d_valid, 1);
        check("issue_ops", {d_dividend, d_divisor}, {32'd17, 32'd5});
        check("r1_idle_0", r1_rsp_valid, 0);
        tick();
        check("wait_busy", {d_valid, d_rsp_valid, busy}, 3'b011);
        tick();
        check("lat_rsp", {r0_rsp_valid, r0_quotient, r0_remainder, r0_err},
              {1'b1, 32'd3, 32'd2, 1'b0});
        check("r1_idle_1", r1_rsp_valid, 0);
        drain();

        // both requesters valid, alternating owners from reset
        do_reset();
        r0_dividend = 50;  r0_divisor = 6;
        r1_dividend = 100; r1_divisor = 7;
        r0_valid = 1'b1;   r1_valid = 1'b1;
        wait_acc(4);
        tick();
        r0_valid = 1'b0;   r1_valid = 1'b0;
        drain();
        check("rr_count", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++)
            check($sformatf("rr_owner%0d", i), acc_log[i], i % 2);

        // zero divisor on r1 bypasses the divider
        iss0 = n_issue;
        send(1, 9, 0);
        check("zd_rsp", {r1_rsp_valid, r1_quotient, r1_remainder, r1_err},
              {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
        check("zd_no_dvalid", d_valid, 0);
        drain();
        check("zd_no_issue", n_issue, iss0);

        // divider never answers: timeout after TO wait cycles
        div_en = 1'b0;
        r0_rsp_ready = 1'b0;
        send(0, 40, 3);
        for (int i = 0; i < TO; i++) tick();
        check("to_not_yet", r0_rsp_valid, 0);
        tick();
        check("to_rsp", {r0_rsp_valid, r0_quotient, r0_remainder, r0_err},
              {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1});
        r0_rsp_ready = 1'b1;
        drain();
        div_en = 1'b1;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        check("stray_idle", {busy, r0_rsp_valid, r1_rsp_valid}, 3'b000);

        // backpressure on both the divider and the requester
        iss0 = n_issue;
        d_ready = 1'b0;
        r0_rsp_ready = 1'b0;
        send(0, 1000, 33);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("issue_hold%0d", i),
                  {d_valid, d_dividend, d_divisor}, {1'b1, 32'd1000, 32'd33});
            tick();
        end
        d_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rsp_hold%0d", i),
                  {r0_rsp_valid, r0_quotient, r0_remainder, d_valid},
                  {1'b1, 32'd30, 32'd10, 1'b0});
            tick();
        end
        r0_rsp_ready = 1'b1;
        drain();
        check("single_issue", n_issue - iss0, 1);

        // reset in WAIT abandons the transaction
        div_en = 1'b0;
        send(0, 20, 4);
        tick();
        check("in_wait", {busy, d_valid}, 2'b10);
        reset = 1'b0;
        tick();
        check_quiet("mid_reset");
        reset = 1'b1;
        sb.delete();
        acc_log.delete();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        check("late_rsp_ignored", {busy, r0_rsp_valid}, 2'b00);
        div_en = 1'b1;
        r0_dividend = 12; r0_divisor = 4;
        r1_dividend = 15; r1_divisor = 5;
        r0_valid = 1'b1;  r1_valid = 1'b1;
        wait_acc(1);
        r0_valid = 1'b0;  r1_valid = 1'b0;
        check("tie_after_reset", acc_log.size() > 0 ? acc_log[0] : 9, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
